// File: rtl/sensor_channel_bank.sv
// sensor_channel_bank: bank of independent saturating sensor channels.
// Each channel holds a clamped value updated by load/inc/dec requests, a
// 4-sample moving average, and a NORMAL/HIGH/LOW alarm FSM with hysteresis.
module sensor_channel_bank #(
    parameter int NUM_CH    = 2,
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 25,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 100,
    parameter int STEP_W    = 4,
    parameter int HYST      = 2
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic [NUM_CH-1:0]       inc_en,
    input  logic [NUM_CH-1:0]       dec_en,
    input  logic [STEP_W-1:0]       step,
    input  logic [NUM_CH-1:0]       load_en,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic [NUM_CH*WIDTH-1:0] thr_hi,
    input  logic [NUM_CH*WIDTH-1:0] thr_lo,
    output logic [NUM_CH*WIDTH-1:0] value,
    output logic [NUM_CH*WIDTH-1:0] avg_value,
    output logic [NUM_CH-1:0]       alarm_hi,
    output logic [NUM_CH-1:0]       alarm_lo,
    output logic [NUM_CH-1:0]       alarm_evt
);

    localparam int W1 = WIDTH + 1;
    localparam int W2 = WIDTH + 2;

    localparam logic [WIDTH:0]   MIN_E  = W1'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_E  = W1'(MAX_VAL);
    localparam logic [WIDTH:0]   HYST_E = W1'(HYST);
    localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VAL);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2
    } state_e;

    logic [WIDTH-1:0] val_q [NUM_CH];
    logic [WIDTH-1:0] val_d [NUM_CH];
    logic [WIDTH-1:0] h1_q  [NUM_CH];
    logic [WIDTH-1:0] h2_q  [NUM_CH];
    logic [WIDTH-1:0] h3_q  [NUM_CH];
    logic [WIDTH-1:0] avg_q [NUM_CH];
    logic [WIDTH-1:0] avg_d [NUM_CH];
    state_e           st_q  [NUM_CH];
    state_e           st_d  [NUM_CH];

    // Next channel value; all arithmetic is one bit wider so it saturates instead of wrapping.
    function automatic logic [WIDTH-1:0] next_val(
        input logic [WIDTH-1:0]  cur,
        input logic              ld,
        input logic              inc,
        input logic              dec,
        input logic [WIDTH-1:0]  lv,
        input logic [STEP_W-1:0] stp
    );
        logic [WIDTH:0] cur_e;
        logic [WIDTH:0] lv_e;
        logic [WIDTH:0] stp_e;
        logic [WIDTH:0] sum_e;
        logic [WIDTH:0] res_e;
        cur_e = {1'b0, cur};
        lv_e  = {1'b0, lv};
        stp_e = W1'(stp);
        sum_e = cur_e + stp_e;
        res_e = cur_e;
        if (ld) begin
            if (lv_e < MIN_E)      res_e = MIN_E;
            else if (lv_e > MAX_E) res_e = MAX_E;
            else                   res_e = lv_e;
        end else if (inc && dec) begin
            res_e = cur_e;
        end else if (inc) begin
            res_e = (sum_e > MAX_E) ? MAX_E : sum_e;
        end else if (dec) begin
            res_e = (cur_e < MIN_E + stp_e) ? MIN_E : cur_e - stp_e;
        end
        return WIDTH'(res_e);
    endfunction

    // Alarm next state from the registered value; HIGH is tested before LOW.
    function automatic state_e fsm_next(
        input state_e           s,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo
    );
        logic [WIDTH:0] v_e;
        logic [WIDTH:0] hi_e;
        logic [WIDTH:0] lo_e;
        state_e         n;
        v_e  = {1'b0, v};
        hi_e = {1'b0, hi};
        lo_e = {1'b0, lo};
        n    = s;
        case (s)
            ST_NORMAL: begin
                if (v_e > hi_e)      n = ST_HIGH;
                else if (v_e < lo_e) n = ST_LOW;
            end
            ST_HIGH:   if (v_e + HYST_E <= hi_e) n = ST_NORMAL;
            ST_LOW:    if (v_e >= lo_e + HYST_E) n = ST_NORMAL;
            default:   n = ST_NORMAL;
        endcase
        return n;
    endfunction

    // Per-channel next value, next average and next alarm state.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            val_d[i] = next_val(val_q[i], load_en[i], inc_en[i], dec_en[i],
                                load_val[i*WIDTH +: WIDTH], step);
            avg_d[i] = WIDTH'((W2'(val_q[i]) + W2'(h1_q[i]) + W2'(h2_q[i]) + W2'(h3_q[i])) >> 2);
            st_d[i]  = fsm_next(st_q[i], val_q[i], thr_hi[i*WIDTH +: WIDTH],
                                thr_lo[i*WIDTH +: WIDTH]);
        end
    end

    // Pack per-channel registers onto the flat output buses.
    always_comb begin
        value     = '0;
        avg_value = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            value[i*WIDTH +: WIDTH]     = val_q[i];
            avg_value[i*WIDTH +: WIDTH] = avg_q[i];
        end
    end

    // Channel value, 3-deep history shift and registered average.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                val_q[i] <= RST_V;
                h1_q[i]  <= RST_V;
                h2_q[i]  <= RST_V;
                h3_q[i]  <= RST_V;
                avg_q[i] <= RST_V;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                val_q[i] <= val_d[i];
                h1_q[i]  <= val_q[i];
                h2_q[i]  <= h1_q[i];
                h3_q[i]  <= h2_q[i];
                avg_q[i] <= avg_d[i];
            end
        end
    end

    // Alarm FSM; flags are registered alongside the state so they show the new state directly.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                st_q[i] <= ST_NORMAL;
            end
            alarm_hi  <= '0;
            alarm_lo  <= '0;
            alarm_evt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                st_q[i]      <= st_d[i];
                alarm_hi[i]  <= (st_d[i] == ST_HIGH);
                alarm_lo[i]  <= (st_d[i] == ST_LOW);
                alarm_evt[i] <= (st_d[i] != st_q[i]) && (st_d[i] != ST_NORMAL);
            end
        end
    end

endmodule
